// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode, condition, ALU and state constants for the CPU control FSM
package cpu_pkg;

    localparam logic [3:0] OP_RTYPE   = 4'b0000;
    localparam logic [3:0] OP_MEM     = 4'b0100;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_BCOND   = 4'b1100;

    // Shared by R-type OpCodeExt and I-type OpCode
    localparam logic [3:0] EXT_ADD    = 4'b0101;
    localparam logic [3:0] EXT_SUB    = 4'b1001;
    localparam logic [3:0] EXT_CMP    = 4'b1011;
    localparam logic [3:0] EXT_AND    = 4'b0001;
    localparam logic [3:0] EXT_OR     = 4'b0010;
    localparam logic [3:0] EXT_XOR    = 4'b0011;
    localparam logic [3:0] EXT_MOV    = 4'b1101;

    localparam logic [3:0] EXT_LSH    = 4'b0100;
    localparam logic [3:0] EXT_LSHI0  = 4'b0000;
    localparam logic [3:0] EXT_LSHI1  = 4'b0001;
    localparam logic [3:0] EXT_LOAD   = 4'b0000;
    localparam logic [3:0] EXT_STOR   = 4'b0100;
    localparam logic [3:0] EXT_JCOND  = 4'b1100;

    localparam logic [3:0] COND_EQ    = 4'b0000;
    localparam logic [3:0] COND_NE    = 4'b0001;
    localparam logic [3:0] COND_CS    = 4'b0010;
    localparam logic [3:0] COND_CC    = 4'b0011;
    localparam logic [3:0] COND_HI    = 4'b0100;
    localparam logic [3:0] COND_LS    = 4'b0101;
    localparam logic [3:0] COND_GT    = 4'b0110;
    localparam logic [3:0] COND_LE    = 4'b0111;
    localparam logic [3:0] COND_FS    = 4'b1000;
    localparam logic [3:0] COND_FC    = 4'b1001;
    localparam logic [3:0] COND_LO    = 4'b1010;
    localparam logic [3:0] COND_HS    = 4'b1011;
    localparam logic [3:0] COND_LT    = 4'b1100;
    localparam logic [3:0] COND_GE    = 4'b1101;
    localparam logic [3:0] COND_UC    = 4'b1110;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_AND    = 4'b0010;
    localparam logic [3:0] ALU_OR     = 4'b0011;
    localparam logic [3:0] ALU_XOR    = 4'b0100;
    localparam logic [3:0] ALU_CMP    = 4'b0101;
    localparam logic [3:0] ALU_PASSB  = 4'b0110;

    localparam logic [2:0] S_FETCH    = 3'd0;
    localparam logic [2:0] S_DECODE   = 3'd1;
    localparam logic [2:0] S_EXEC     = 3'd2;
    localparam logic [2:0] S_WB       = 3'd3;
    localparam logic [2:0] S_MEM      = 3'd4;
    localparam logic [2:0] S_PCINC    = 3'd5;
    localparam logic [2:0] S_HALT     = 3'd6;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_ITYPE,
        CLS_SHIFT,
        CLS_LOAD,
        CLS_STOR,
        CLS_BCOND,
        CLS_JCOND,
        CLS_ILLEGAL
    } instr_class_t;

    // Returns {valid, alu code} for an ALU-class operation code
    function automatic logic [4:0] arith_alu(input logic [3:0] code);
        case (code)
            EXT_ADD: arith_alu = {1'b1, ALU_ADD};
            EXT_SUB: arith_alu = {1'b1, ALU_SUB};
            EXT_CMP: arith_alu = {1'b1, ALU_CMP};
            EXT_AND: arith_alu = {1'b1, ALU_AND};
            EXT_OR:  arith_alu = {1'b1, ALU_OR};
            EXT_XOR: arith_alu = {1'b1, ALU_XOR};
            EXT_MOV: arith_alu = {1'b1, ALU_PASSB};
            default: arith_alu = {1'b0, ALU_ADD};
        endcase
    endfunction

endpackage

// File: rtl/cpu_instr_decode.sv
// rtl/cpu_instr_decode.sv - combinational instruction class / ALU code decoder
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0]   opcode,
    input  logic [3:0]   ext,
    output instr_class_t cls,
    output logic [3:0]   alu_code,
    output logic         sext,
    output logic         illegal
);

    logic [4:0] r_alu;
    logic [4:0] i_alu;

    assign r_alu = arith_alu(ext);
    assign i_alu = arith_alu(opcode);

    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_code = ALU_ADD;
        sext     = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (r_alu[4]) begin
                    cls      = CLS_RTYPE;
                    alu_code = r_alu[3:0];
                end
            end
            OP_MEM: begin
                case (ext)
                    EXT_LOAD:  cls = CLS_LOAD;
                    EXT_STOR:  cls = CLS_STOR;
                    EXT_JCOND: cls = CLS_JCOND;
                    default:   cls = CLS_ILLEGAL;
                endcase
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH || ext == EXT_LSHI0 || ext == EXT_LSHI1)
                    cls = CLS_SHIFT;
            end
            OP_BCOND: begin
                cls  = CLS_BCOND;
                sext = 1'b1;
            end
            default: begin
                // Immediate forms: logical ops zero-extend, the rest sign-extend
                if (i_alu[4]) begin
                    cls      = CLS_ITYPE;
                    alu_code = i_alu[3:0];
                    sext     = !(i_alu[3:0] == ALU_AND || i_alu[3:0] == ALU_OR ||
                                 i_alu[3:0] == ALU_XOR);
                end
            end
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/cpu_control_fsm.sv
// rtl/cpu_control_fsm.sv - multicycle control FSM sequencing the 16-bit CPU datapath
module cpu_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic [4:0]  flags,
    input  logic        mem_ready,
    output logic        ir_en,
    output logic        srcRegEn,
    output logic        dstRegEn,
    output logic        immRegEn,
    output logic        pcRegEn,
    output logic        resultRegEn,
    output logic        regFileEn,
    output logic        signEn,
    output logic        pcRegMuxEn,
    output logic [1:0]  mux4En,
    output logic        regImmMuxEn,
    output logic        shiftALUMuxEn,
    output logic        exMemResultEn,
    output logic [3:0]  aluControl,
    output logic        flag_en,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        halted
);

    logic [2:0]   state;
    logic [2:0]   state_nxt;
    logic [15:4]  ir;
    logic [3:0]   unused_rsrc;
    instr_class_t dec_cls;
    logic [3:0]   dec_alu;
    logic         dec_sext;
    logic         dec_illegal;
    logic         cond_true;
    logic         is_cmp;
    logic         c_f, l_f, f_f, z_f, n_f;

    // Rsrc is consumed by the datapath's own field registers
    assign unused_rsrc = instruction[3:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_FETCH;
            ir    <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && mem_ready)
                ir <= instruction[15:4];
        end
    end

    cpu_instr_decode u_decode (
        .opcode   (ir[15:12]),
        .ext      (ir[7:4]),
        .cls      (dec_cls),
        .alu_code (dec_alu),
        .sext     (dec_sext),
        .illegal  (dec_illegal)
    );

    assign {c_f, l_f, f_f, z_f, n_f} = flags;
    assign is_cmp = (dec_alu == ALU_CMP);

    always_comb begin
        case (ir[11:8])
            COND_EQ: cond_true = z_f;
            COND_NE: cond_true = !z_f;
            COND_CS: cond_true = c_f;
            COND_CC: cond_true = !c_f;
            COND_HI: cond_true = l_f;
            COND_LS: cond_true = !l_f;
            COND_GT: cond_true = n_f;
            COND_LE: cond_true = !n_f;
            COND_FS: cond_true = f_f;
            COND_FC: cond_true = !f_f;
            COND_LO: cond_true = !l_f && !z_f;
            COND_HS: cond_true = l_f || z_f;
            COND_LT: cond_true = !n_f && !z_f;
            COND_GE: cond_true = n_f || z_f;
            COND_UC: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC: begin
                if (dec_illegal) begin
                    state_nxt = S_HALT;
                end else begin
                    case (dec_cls)
                        CLS_RTYPE, CLS_ITYPE: state_nxt = is_cmp ? S_PCINC : S_WB;
                        CLS_SHIFT:            state_nxt = S_WB;
                        CLS_LOAD, CLS_STOR:   state_nxt = S_MEM;
                        CLS_BCOND, CLS_JCOND: state_nxt = cond_true ? S_FETCH : S_PCINC;
                        default:              state_nxt = S_HALT;
                    endcase
                end
            end
            S_WB:     state_nxt = S_PCINC;
            S_MEM:    if (mem_ready) state_nxt = S_PCINC;
            S_PCINC:  state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Gated by reset so an in-flight request drops the instant reset asserts
    always_comb begin
        ir_en         = 1'b0;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        pcRegEn       = 1'b0;
        resultRegEn   = 1'b0;
        regFileEn     = 1'b0;
        signEn        = 1'b0;
        pcRegMuxEn    = 1'b0;
        mux4En        = 2'd0;
        regImmMuxEn   = 1'b0;
        shiftALUMuxEn = 1'b0;
        exMemResultEn = 1'b0;
        aluControl    = ALU_ADD;
        flag_en       = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        halted        = 1'b0;
        if (reset) begin
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    ir_en   = mem_ready;
                end
                S_DECODE: begin
                    srcRegEn = 1'b1;
                    dstRegEn = 1'b1;
                    immRegEn = 1'b1;
                    signEn   = dec_sext;
                end
                S_EXEC: begin
                    case (dec_cls)
                        CLS_RTYPE, CLS_ITYPE: begin
                            pcRegMuxEn  = 1'b1;
                            mux4En      = (dec_cls == CLS_ITYPE) ? 2'd1 : 2'd0;
                            resultRegEn = 1'b1;
                            aluControl  = dec_alu;
                            signEn      = (dec_cls == CLS_ITYPE) && dec_sext;
                            flag_en     = (dec_alu == ALU_ADD) || (dec_alu == ALU_SUB) || is_cmp;
                        end
                        CLS_SHIFT: begin
                            shiftALUMuxEn = 1'b1;
                            regImmMuxEn   = (ir[7:4] != EXT_LSH);
                            resultRegEn   = 1'b1;
                        end
                        CLS_BCOND: begin
                            if (cond_true) begin
                                mux4En  = 2'd1;
                                signEn  = 1'b1;
                                pcRegEn = 1'b1;
                            end
                        end
                        CLS_JCOND: begin
                            if (cond_true) begin
                                pcRegMuxEn = 1'b1;
                                mux4En     = 2'd3;
                                pcRegEn    = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_WB: regFileEn = 1'b1;
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (dec_cls == CLS_STOR);
                    if (mem_ready && dec_cls == CLS_LOAD) begin
                        exMemResultEn = 1'b1;
                        regFileEn     = 1'b1;
                    end
                end
                S_PCINC: begin
                    mux4En  = 2'd2;
                    pcRegEn = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// tb/tb_cpu_control_fsm.sv - directed self-checking bench for cpu_control_fsm
module tb_cpu_control_fsm;

    logic        clk;
    logic        reset;
    logic [15:0] instruction;
    logic [4:0]  flags;
    logic        mem_ready;
    logic        ir_en, srcRegEn, dstRegEn, immRegEn, pcRegEn, resultRegEn, regFileEn;
    logic        signEn, pcRegMuxEn, regImmMuxEn, shiftALUMuxEn, exMemResultEn;
    logic [1:0]  mux4En;
    logic [3:0]  aluControl;
    logic        flag_en, mem_req, mem_we, addr_sel, halted;

    int checks = 0;
    int errors = 0;

    localparam logic [16:0] M_IR   = 17'd1 << 16;
    localparam logic [16:0] M_SRC  = 17'd1 << 15;
    localparam logic [16:0] M_DST  = 17'd1 << 14;
    localparam logic [16:0] M_IMM  = 17'd1 << 13;
    localparam logic [16:0] M_PCE  = 17'd1 << 12;
    localparam logic [16:0] M_RES  = 17'd1 << 11;
    localparam logic [16:0] M_RF   = 17'd1 << 10;
    localparam logic [16:0] M_SGN  = 17'd1 << 9;
    localparam logic [16:0] M_PCM  = 17'd1 << 8;
    localparam logic [16:0] M_RIM  = 17'd1 << 7;
    localparam logic [16:0] M_SHM  = 17'd1 << 6;
    localparam logic [16:0] M_EXM  = 17'd1 << 5;
    localparam logic [16:0] M_FLG  = 17'd1 << 4;
    localparam logic [16:0] M_MREQ = 17'd1 << 3;
    localparam logic [16:0] M_MWE  = 17'd1 << 2;
    localparam logic [16:0] M_ASEL = 17'd1 << 1;
    localparam logic [16:0] M_HLT  = 17'd1;
    localparam logic [16:0] M_DEC  = M_SRC | M_DST | M_IMM;
    localparam logic [16:0] M_NONE = 17'd0;

    logic [16:0] bits;
    logic [22:0] obs;
    assign bits = {ir_en, srcRegEn, dstRegEn, immRegEn, pcRegEn, resultRegEn, regFileEn,
                   signEn, pcRegMuxEn, regImmMuxEn, shiftALUMuxEn, exMemResultEn, flag_en,
                   mem_req, mem_we, addr_sel, halted};
    assign obs = {bits, mux4En, aluControl};

    cpu_control_fsm dut (
        .clk           (clk),
        .reset         (reset),
        .instruction   (instruction),
        .flags         (flags),
        .mem_ready     (mem_ready),
        .ir_en         (ir_en),
        .srcRegEn      (srcRegEn),
        .dstRegEn      (dstRegEn),
        .immRegEn      (immRegEn),
        .pcRegEn       (pcRegEn),
        .resultRegEn   (resultRegEn),
        .regFileEn     (regFileEn),
        .signEn        (signEn),
        .pcRegMuxEn    (pcRegMuxEn),
        .mux4En        (mux4En),
        .regImmMuxEn   (regImmMuxEn),
        .shiftALUMuxEn (shiftALUMuxEn),
        .exMemResultEn (exMemResultEn),
        .aluControl    (aluControl),
        .flag_en       (flag_en),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        @(posedge clk);
        #2;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL reset_hold: got %06h, expected %06h", obs, 23'd0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {M_MREQ, 6'd0}) begin
            errors++;
            $display("FAIL reset_release: got %06h, expected %06h", obs, {M_MREQ, 6'd0});
        end
        instruction = 16'h4305;
        mem_ready   = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        mem_ready = 1'b0;
        @(posedge clk); #2;
        checks++;
        if (obs !== {M_MREQ | M_ASEL, 6'd0}) begin
            errors++;
            $display("FAIL reset_mid_mem_pre: got %06h, expected %06h", obs, {M_MREQ | M_ASEL, 6'd0});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL reset_mid_mem_drop: got %06h, expected %06h", obs, 23'd0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {M_MREQ, 6'd0}) begin
            errors++;
            $display("FAIL reset_after_mem: got %06h, expected %06h", obs, {M_MREQ, 6'd0});
        end
    endtask

    task automatic test_rtype(input string name, input logic [15:0] instr,
                              input logic [3:0] alu, input logic flg);
        logic [23:0] tbl [6];
        instruction = instr;
        tbl[0] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[1] = {1'b1, M_DEC, 2'd0, 4'd0};
        tbl[2] = {1'b1, M_PCM | M_RES | (flg ? M_FLG : M_NONE), 2'd0, alu};
        tbl[3] = {1'b1, M_RF, 2'd0, 4'd0};
        tbl[4] = {1'b1, M_PCE, 2'd2, 4'd0};
        tbl[5] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %06h, expected %06h", name, i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_itype(input string name, input logic [15:0] instr, input logic [3:0] alu,
                              input logic sgn, input logic flg, input logic cmp);
        logic [23:0] tbl [6];
        int n = 0;
        instruction = instr;
        tbl[n++] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[n++] = {1'b1, M_DEC | (sgn ? M_SGN : M_NONE), 2'd0, 4'd0};
        tbl[n++] = {1'b1, M_PCM | M_RES | (flg ? M_FLG : M_NONE) | (sgn ? M_SGN : M_NONE), 2'd1, alu};
        if (!cmp) tbl[n++] = {1'b1, M_RF, 2'd0, 4'd0};
        tbl[n++] = {1'b1, M_PCE, 2'd2, 4'd0};
        tbl[n++] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < n; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %06h, expected %06h", name, i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_shift(input string name, input logic [15:0] instr, input logic imm);
        logic [23:0] tbl [6];
        instruction = instr;
        tbl[0] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[1] = {1'b1, M_DEC, 2'd0, 4'd0};
        tbl[2] = {1'b1, M_SHM | M_RES | (imm ? M_RIM : M_NONE), 2'd0, 4'd0};
        tbl[3] = {1'b1, M_RF, 2'd0, 4'd0};
        tbl[4] = {1'b1, M_PCE, 2'd2, 4'd0};
        tbl[5] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %06h, expected %06h", name, i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_load_wait();
        logic [23:0] tbl [9];
        instruction = 16'h4305;
        tbl[0] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[1] = {1'b1, M_DEC, 2'd0, 4'd0};
        tbl[2] = {1'b1, M_NONE, 2'd0, 4'd0};
        tbl[3] = {1'b0, M_MREQ | M_ASEL, 2'd0, 4'd0};
        tbl[4] = {1'b0, M_MREQ | M_ASEL, 2'd0, 4'd0};
        tbl[5] = {1'b0, M_MREQ | M_ASEL, 2'd0, 4'd0};
        tbl[6] = {1'b1, M_MREQ | M_ASEL | M_EXM | M_RF, 2'd0, 4'd0};
        tbl[7] = {1'b1, M_PCE, 2'd2, 4'd0};
        tbl[8] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < 9; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL load_wait cycle %0d: got %06h, expected %06h", i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_store();
        logic [23:0] tbl [6];
        instruction = 16'h4345;
        tbl[0] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[1] = {1'b1, M_DEC, 2'd0, 4'd0};
        tbl[2] = {1'b1, M_NONE, 2'd0, 4'd0};
        tbl[3] = {1'b1, M_MREQ | M_ASEL | M_MWE, 2'd0, 4'd0};
        tbl[4] = {1'b1, M_PCE, 2'd2, 4'd0};
        tbl[5] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL store cycle %0d: got %06h, expected %06h", i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
    endtask

    task automatic test_branch(input string name, input logic [15:0] instr, input logic [4:0] flg,
                               input logic taken, input logic is_j);
        logic [23:0] tbl [5];
        int n = 0;
        instruction = instr;
        flags       = flg;
        tbl[n++] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[n++] = {1'b1, M_DEC | (is_j ? M_NONE : M_SGN), 2'd0, 4'd0};
        if (taken && is_j)
            tbl[n++] = {1'b1, M_PCE | M_PCM, 2'd3, 4'd0};
        else if (taken)
            tbl[n++] = {1'b1, M_PCE | M_SGN, 2'd1, 4'd0};
        else begin
            tbl[n++] = {1'b1, M_NONE, 2'd0, 4'd0};
            tbl[n++] = {1'b1, M_PCE, 2'd2, 4'd0};
        end
        tbl[n++] = {1'b0, M_MREQ, 2'd0, 4'd0};
        for (int i = 0; i < n; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL %s cycle %0d: got %06h, expected %06h", name, i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
        flags = 5'd0;
    endtask

    task automatic test_halt();
        logic [23:0] tbl [6];
        instruction = 16'hF000;
        tbl[0] = {1'b1, M_IR | M_MREQ, 2'd0, 4'd0};
        tbl[1] = {1'b1, M_DEC, 2'd0, 4'd0};
        tbl[2] = {1'b1, M_NONE, 2'd0, 4'd0};
        tbl[3] = {1'b1, M_HLT, 2'd0, 4'd0};
        tbl[4] = {1'b1, M_HLT, 2'd0, 4'd0};
        tbl[5] = {1'b0, M_HLT, 2'd0, 4'd0};
        for (int i = 0; i < 6; i++) begin
            mem_ready = tbl[i][23];
            #1;
            checks++;
            if (obs !== tbl[i][22:0]) begin
                errors++;
                $display("FAIL halt cycle %0d: got %06h, expected %06h", i, obs, tbl[i][22:0]);
            end
            @(posedge clk);
            #2;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== 23'd0) begin
            errors++;
            $display("FAIL halt_reset: got %06h, expected %06h", obs, 23'd0);
        end
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (obs !== {M_MREQ, 6'd0}) begin
            errors++;
            $display("FAIL halt_release: got %06h, expected %06h", obs, {M_MREQ, 6'd0});
        end
    endtask

    initial begin
        reset       = 1'b0;
        instruction = 16'h0000;
        flags       = 5'd0;
        mem_ready   = 1'b0;
        test_reset();
        test_rtype("add", 16'h0152, 4'd0, 1'b1);
        test_rtype("sub", 16'h0192, 4'd1, 1'b1);
        test_rtype("xor", 16'h0132, 4'd4, 1'b0);
        test_rtype("mov", 16'h01D2, 4'd6, 1'b0);
        test_itype("cmpi", 16'hB207, 4'd5, 1'b1, 1'b1, 1'b1);
        test_itype("andi", 16'h1203, 4'd2, 1'b0, 1'b0, 1'b0);
        test_itype("addi", 16'h5203, 4'd0, 1'b1, 1'b1, 1'b0);
        test_shift("lshi", 16'h8213, 1'b1);
        test_shift("lsh", 16'h8242, 1'b0);
        test_load_wait();
        test_store();
        test_branch("beq_taken", 16'hC005, 5'b00010, 1'b1, 1'b0);
        test_branch("beq_not", 16'hC005, 5'b00000, 1'b0, 1'b0);
        test_branch("blo_taken", 16'hCA05, 5'b00000, 1'b1, 1'b0);
        test_branch("bge_not", 16'hCD05, 5'b00000, 1'b0, 1'b0);
        test_branch("bhi_taken", 16'hC405, 5'b01000, 1'b1, 1'b0);
        test_branch("bcs_taken", 16'hC205, 5'b10000, 1'b1, 1'b0);
        test_branch("juc_taken", 16'h4EC3, 5'b00000, 1'b1, 1'b1);
        test_branch("jnever_not", 16'h4FC3, 5'b11111, 1'b0, 1'b1);
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
